// File: rtl/adau1761_pkg.sv
// Shared types and constants for the ADAU1761 configuration sequencer:
// sequencer states, key register addresses and the boot-time register table.
package adau1761_pkg;

  typedef enum logic [3:0] {
    PWRUP,
    DUMMY,
    BOOT,
    BOOT_WAIT,
    VERIFY,
    VERIFY_WAIT,
    IDLE,
    RUN_WAIT,
    FAIL
  } cfg_state_t;

  localparam logic [15:0] ADAU_REG_CLKCTRL = 16'h4000;
  localparam logic [15:0] ADAU_REG_PLLCTRL = 16'h4002;

  // Each entry is {addr[15:0], data[7:0]}; the core clock must be enabled first.
  localparam logic [23:0] ADAU_BOOT_TABLE [16] = '{
    {ADAU_REG_CLKCTRL, 8'h01},
    {ADAU_REG_PLLCTRL, 8'h00},
    {16'h4015,         8'h01},
    {16'h4016,         8'h00},
    {16'h4019,         8'h03},
    {16'h401C,         8'h21},
    {16'h4029,         8'h03},
    {16'h402A,         8'h03},
    {16'h40F9,         8'h7F},
    {16'h40FA,         8'h03},
    {16'h4023,         8'hE7},
    {16'h4024,         8'hE7},
    {16'h4025,         8'hE7},
    {16'h4026,         8'hE7},
    {16'h4017,         8'h00},
    {16'h40F2,         8'h01}
  };

endpackage

// File: rtl/adau1761_boot_rom.sv
// Combinational lookup of one boot table entry, split into address and data.
import adau1761_pkg::*;

module adau1761_boot_rom (
  input  logic [3:0]  index,
  output logic [15:0] addr,
  output logic [7:0]  data
);

  assign {addr, data} = ADAU_BOOT_TABLE[index];

endmodule

// File: rtl/adau1761_cfg_sequencer.sv
// Boots the ADAU1761 (power-up wait, SPI-mode dummies, boot table), then serves
// runtime register requests. Define ADAU_CFG_READBACK_EN to verify each boot write.
import adau1761_pkg::*;

module adau1761_cfg_sequencer #(
  parameter int PWRUP_CYCLES = 1024,
  parameter int DUMMY_WRITES = 3,
  parameter int BOOT_LEN     = 8,
  parameter int MAX_RETRY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_dummy,
  output logic        cmd_rw,
  output logic [15:0] cmd_addr,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_rdata,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic [7:0]  req_rdata,
  output logic        req_done,
  output logic        boot_done,
  output logic        error
);

  localparam int PW_W = $clog2(PWRUP_CYCLES + 1);
  localparam int DW_W = $clog2(DUMMY_WRITES + 1);

  cfg_state_t      state;
  logic [PW_W-1:0] pwr_cnt;
  logic [DW_W-1:0] dummy_cnt;
  logic [3:0]      boot_idx;
  logic            busy;
  logic [15:0]     rom_addr;
  logic [7:0]      rom_data;
  logic            last_entry;

`ifdef ADAU_CFG_READBACK_EN
  localparam int RT_W = $clog2(MAX_RETRY + 2);
  logic [RT_W-1:0] retry_cnt;
`else
  assign error = 1'b0;
`endif

  adau1761_boot_rom u_boot_rom (
    .index (boot_idx),
    .addr  (rom_addr),
    .data  (rom_data)
  );

  assign last_entry = (boot_idx == 4'(BOOT_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PWRUP;
      pwr_cnt   <= '0;
      dummy_cnt <= '0;
      boot_idx  <= '0;
      busy      <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_dummy <= 1'b0;
      cmd_rw    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      req_ready <= 1'b0;
      req_rdata <= '0;
      req_done  <= 1'b0;
      boot_done <= 1'b0;
`ifdef ADAU_CFG_READBACK_EN
      retry_cnt <= '0;
      error     <= 1'b0;
`endif
    end else begin
      req_done <= 1'b0;
      case (state)
        PWRUP: begin
          if (pwr_cnt == PW_W'(PWRUP_CYCLES - 1)) begin
            pwr_cnt <= '0;
            state   <= DUMMY;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end

        // busy marks a dummy in flight so the next one waits for its completion
        DUMMY: begin
          if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            busy      <= 1'b1;
          end else if (!cmd_valid && !busy) begin
            cmd_valid <= 1'b1;
            cmd_dummy <= 1'b1;
            cmd_rw    <= 1'b0;
          end
          if (busy && rsp_valid) begin
            busy <= 1'b0;
            if (dummy_cnt == DW_W'(DUMMY_WRITES - 1)) begin
              dummy_cnt <= '0;
              boot_idx  <= '0;
              state     <= BOOT;
            end else begin
              dummy_cnt <= dummy_cnt + 1'b1;
            end
          end
        end

        BOOT: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_dummy <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= rom_addr;
            cmd_wdata <= rom_data;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= BOOT_WAIT;
          end
        end

        BOOT_WAIT: begin
          if (rsp_valid) begin
`ifdef ADAU_CFG_READBACK_EN
            state <= VERIFY;
`else
            if (last_entry) begin
              boot_done <= 1'b1;
              state     <= IDLE;
            end else begin
              boot_idx <= boot_idx + 1'b1;
              state    <= BOOT;
            end
`endif
          end
        end

`ifdef ADAU_CFG_READBACK_EN
        VERIFY: begin
          if (!cmd_valid) begin
            cmd_valid <= 1'b1;
            cmd_dummy <= 1'b0;
            cmd_rw    <= 1'b1;
            cmd_addr  <= rom_addr;
          end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= VERIFY_WAIT;
          end
        end

        VERIFY_WAIT: begin
          if (rsp_valid) begin
            if (rsp_rdata == rom_data) begin
              retry_cnt <= '0;
              if (last_entry) begin
                boot_done <= 1'b1;
                state     <= IDLE;
              end else begin
                boot_idx <= boot_idx + 1'b1;
                state    <= BOOT;
              end
            end else if (retry_cnt == RT_W'(MAX_RETRY)) begin
              error <= 1'b1;
              state <= FAIL;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= BOOT;
            end
          end
        end
`endif

        // req_ready is a one-cycle accept pulse; the command goes out the cycle after
        IDLE: begin
          if (req_ready) begin
            req_ready <= 1'b0;
            cmd_valid <= 1'b1;
            state     <= RUN_WAIT;
          end else if (req_valid && !cmd_valid) begin
            req_ready <= 1'b1;
            cmd_dummy <= 1'b0;
            cmd_rw    <= req_rw;
            cmd_addr  <= req_addr;
            cmd_wdata <= req_wdata;
          end
        end

        RUN_WAIT: begin
          if (cmd_valid) begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
            end
          end else if (rsp_valid) begin
            req_done <= 1'b1;
            if (cmd_rw) begin
              req_rdata <= rsp_rdata;
            end
            state <= IDLE;
          end
        end

        FAIL: begin
          cmd_valid <= 1'b0;
          req_ready <= 1'b0;
        end

        default: begin
          state <= PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adau1761_cfg_sequencer.sv
// Directed self-checking bench for adau1761_cfg_sequencer with a simple SPI
// engine model (fixed latency, byte memory). Honours ADAU_CFG_READBACK_EN.
`timescale 1ns/1ps

module tb_adau1761_cfg_sequencer;

  localparam int PWRUP = 16;
  localparam int LAT   = 4;
`ifdef ADAU_CFG_READBACK_EN
  localparam int BOOT_RSP    = 3 + 16;
  localparam int LAST_WR_IDX = 17;
`else
  localparam int BOOT_RSP    = 3 + 8;
  localparam int LAST_WR_IDX = 10;
`endif

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dummy;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  req_rdata;
  logic        req_done;
  logic        boot_done;
  logic        error;

  int errors;
  int checks;

  logic        log_dummy [64];
  logic        log_rw    [64];
  logic [15:0] log_addr  [64];
  logic [7:0]  log_wdata [64];
  int          n_txn;
  int          n_rsp;
  int          eng_cnt;
  logic [7:0]  pend_rdata;
  logic        corrupt;
  logic [7:0]  mem [logic [15:0]];

  adau1761_cfg_sequencer #(
    .PWRUP_CYCLES (PWRUP),
    .DUMMY_WRITES (3),
    .BOOT_LEN     (8),
    .MAX_RETRY    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dummy (cmd_dummy),
    .cmd_rw    (cmd_rw),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .req_done  (req_done),
    .boot_done (boot_done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: samples the handshake 1ns after the falling edge, answers LAT cycles later.
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      eng_cnt   = 0;
      rsp_valid = 1'b0;
    end else begin
      rsp_valid = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = pend_rdata;
          n_rsp++;
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (n_txn < 64) begin
          log_dummy[n_txn] = cmd_dummy;
          log_rw[n_txn]    = cmd_rw;
          log_addr[n_txn]  = cmd_addr;
          log_wdata[n_txn] = cmd_wdata;
        end
        n_txn++;
        pend_rdata = 8'h00;
        if (!cmd_dummy && !cmd_rw) begin
          mem[cmd_addr] = cmd_wdata;
        end else if (!cmd_dummy && cmd_rw) begin
          if (corrupt && cmd_addr == 16'h4000)
            pend_rdata = 8'h00;
          else if (mem.exists(cmd_addr))
            pend_rdata = mem[cmd_addr];
          else
            pend_rdata = 8'hFF;
        end
        eng_cnt = LAT;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic rw,
                               input logic [15:0] addr, input logic [7:0] wdata);
    req_valid = valid;
    req_rw    = rw;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  initial begin
    int guard;
    int seen;
    int nd;
    int n_wr;
    int n_rd;
    logic        early_ready;
    logic        stable;
    logic        cap_dummy;
    logic        cap_rw;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;

    errors     = 0;
    checks     = 0;
    n_txn      = 0;
    n_rsp      = 0;
    eng_cnt    = 0;
    corrupt    = 1'b0;
    pend_rdata = 8'h00;
    rsp_valid  = 1'b0;
    rsp_rdata  = 8'h00;
    cmd_ready  = 1'b1;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_cmd_dummy", 32'(cmd_dummy), 32'd0);
    checkOutput("rst_cmd_addr",  32'(cmd_addr),  32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_req_done",  32'(req_done),  32'd0);
    checkOutput("rst_req_rdata", 32'(req_rdata), 32'd0);
    checkOutput("rst_boot_done", 32'(boot_done), 32'd0);
    checkOutput("rst_error",     32'(error),     32'd0);

    // Power-up wait, then the first dummy
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < PWRUP; i++) begin
      @(negedge clk);
      if (cmd_valid) seen++;
    end
    checkOutput("pwrup_quiet", 32'(seen), 32'd0);
    @(negedge clk);
    checkOutput("first_dummy_valid", 32'(cmd_valid), 32'd1);
    checkOutput("first_dummy_flag",  32'(cmd_dummy), 32'd1);

    // Stall the first boot write for 10 cycles
    guard = 0;
    while (n_txn < 3 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("dummy_txns", 32'(n_txn), 32'd3);
    cmd_ready = 1'b0;
    guard = 0;
    while (!cmd_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("boot_cmd_timeout", 32'(cmd_valid), 32'd1);
    cap_dummy = cmd_dummy;
    cap_rw    = cmd_rw;
    cap_addr  = cmd_addr;
    cap_wdata = cmd_wdata;
    stable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_addr != cap_addr || cmd_wdata != cap_wdata ||
          cmd_rw != cap_rw || cmd_dummy != cap_dummy)
        stable = 1'b0;
    end
    checkOutput("stall_stable",   32'(stable),    32'd1);
    checkOutput("stall_no_issue", 32'(n_txn),     32'd3);
    checkOutput("boot0_addr",     32'(cap_addr),  32'h4000);
    checkOutput("boot0_wdata",    32'(cap_wdata), 32'h01);
    checkOutput("boot0_dummy",    32'(cap_dummy), 32'd0);
    checkOutput("boot0_rw",       32'(cap_rw),    32'd0);
    cmd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stall_single_txn", 32'(n_txn), 32'd4);

    // Hold a read request during boot; it must wait for boot_done
    applyStimulus(1'b1, 1'b1, 16'h4002, 8'h00);
    early_ready = 1'b0;
    guard = 0;
    while (!boot_done && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (req_ready && !boot_done) early_ready = 1'b1;
    end
    checkOutput("boot_done_timeout", 32'(boot_done),   32'd1);
    checkOutput("boot_rsp_count",    32'(n_rsp),       32'(BOOT_RSP));
    checkOutput("no_early_ready",    32'(early_ready), 32'd0);
    checkOutput("boot_error_clear",  32'(error),       32'd0);
    nd = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < n_txn && log_dummy[i]) nd++;
    end
    checkOutput("dummy_total",     32'(nd),                     32'd3);
    checkOutput("last_boot_addr",  32'(log_addr[LAST_WR_IDX]),  32'h402A);
    checkOutput("last_boot_wdata", 32'(log_wdata[LAST_WR_IDX]), 32'h03);
    mem[16'h4002] = 8'h5A;

    // Runtime read
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rd_req_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("rd_req_ready_pulse", 32'(req_ready), 32'd0);
    guard = 0;
    while (!req_done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rd_req_done",  32'(req_done),  32'd1);
    checkOutput("rd_req_rdata", 32'(req_rdata), 32'h5A);
    checkOutput("rd_cmd_rw",    32'(log_rw[n_txn-1]),   32'd1);
    checkOutput("rd_cmd_addr",  32'(log_addr[n_txn-1]), 32'h4002);
    @(negedge clk);
    checkOutput("rd_done_pulse", 32'(req_done), 32'd0);

    // Runtime write leaves req_rdata untouched
    applyStimulus(1'b1, 1'b0, 16'h4023, 8'h55);
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("wr_req_ready", 32'(req_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    guard = 0;
    while (!req_done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("wr_req_done",   32'(req_done),  32'd1);
    checkOutput("wr_req_rdata",  32'(req_rdata), 32'h5A);
    checkOutput("wr_cmd_addr",   32'(log_addr[n_txn-1]),  32'h4023);
    checkOutput("wr_cmd_wdata",  32'(log_wdata[n_txn-1]), 32'h55);
    checkOutput("wr_cmd_rw",     32'(log_rw[n_txn-1]),    32'd0);

    // Reset while a boot write is outstanding
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_txn = 0;
    n_rsp = 0;
    guard = 0;
    while (n_txn < 4 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("bw_reach", 32'(n_txn), 32'd4);
    reset = 1'b1;
    #1;
    checkOutput("bw_rst_cmd_valid", 32'(cmd_valid), 32'd0);
    checkOutput("bw_rst_cmd_addr",  32'(cmd_addr),  32'd0);
    checkOutput("bw_rst_cmd_wdata", 32'(cmd_wdata), 32'd0);
    checkOutput("bw_rst_req_rdata", 32'(req_rdata), 32'd0);
    checkOutput("bw_rst_boot_done", 32'(boot_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_txn = 0;
    n_rsp = 0;
    seen  = 0;
    for (int i = 0; i < PWRUP; i++) begin
      @(negedge clk);
      if (cmd_valid || rsp_valid) seen++;
    end
    checkOutput("restart_quiet", 32'(seen), 32'd0);
    @(negedge clk);
    checkOutput("restart_dummy", 32'(cmd_valid && cmd_dummy), 32'd1);
    guard = 0;
    while (!boot_done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("restart_boot_done", 32'(boot_done), 32'd1);
    checkOutput("restart_rsp_count", 32'(n_rsp),     32'(BOOT_RSP));

`ifdef ADAU_CFG_READBACK_EN
    // Readback of CLKCTRL always wrong: two rewrites, then terminal failure
    reset = 1'b1;
    repeat (2) @(negedge clk);
    corrupt = 1'b1;
    reset   = 1'b0;
    n_txn   = 0;
    n_rsp   = 0;
    guard   = 0;
    while (!error && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rb_error",     32'(error),     32'd1);
    checkOutput("rb_boot_done", 32'(boot_done), 32'd0);
    n_wr = 0;
    n_rd = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < n_txn && !log_dummy[i] && log_addr[i] == 16'h4000) begin
        if (log_rw[i]) n_rd++;
        else n_wr++;
      end
    end
    checkOutput("rb_writes", 32'(n_wr), 32'd3);
    checkOutput("rb_reads",  32'(n_rd), 32'd3);
    applyStimulus(1'b1, 1'b1, 16'h4002, 8'h00);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready || cmd_valid) seen++;
    end
    checkOutput("rb_refuse_req", 32'(seen),  32'd0);
    checkOutput("rb_error_hold", 32'(error), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 8'h00);
`else
    n_wr = 0;
    n_rd = 0;
    checkOutput("nrb_error_tied", 32'(error), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
